lcd_write_sequencer: RTL and testbench

LCD_WRITE_SEQUENCER -- requirements
Module: lcd_write_sequencer

---
 rtl/lcd_write_sequencer_if.sv | 12 +
 rtl/lcd_write_sequencer.sv | 139 +++++++++++++
 tb/tb_lcd_write_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_sequencer_if.sv
// Host-side register bus feeding the LCD write sequencer.
interface lcd_write_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] commData;
  logic [ADDR_W-1:0] commAddr;
  logic              wrEn;

  modport master (output commData, commAddr, wrEn);
  modport slave  (input  commData, commAddr, wrEn);
endinterface

// File: rtl/lcd_write_sequencer.sv
// Queues host writes and replays them as 8080-style LCD write cycles
// (setup / WR-low / hold), chaining back-to-back transfers with CS held low.
module lcd_write_sequencer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int WR_LOW_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  lcd_write_sequencer_if.slave          bus,
  output logic [7:0]                    dispData,
  output logic                          lcdRs,
  output logic                          lcdWr,
  output logic                          lcdRd,
  output logic                          lcdCs,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          ovfErr
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [8:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] wdata;
  logic              ctrl, push_req, push_ok, flush, clr, full, avail, pop;

  assign wdata = bus.commData;
  assign lcdRd = 1'b1;
  assign busy  = (state != IDLE) || (fifoCount != '0);

  // Decode the host write and decide this edge's push/pop; flush empties the
  // queue before the pop is considered, so nothing queued escapes a flush.
  always_comb begin
    ctrl     = bus.wrEn && (bus.commAddr == ADDR_W'(1));
    push_req = bus.wrEn && ((bus.commAddr == ADDR_W'(2)) || (bus.commAddr == ADDR_W'(3)));
    flush    = ctrl && wdata[1];
    clr      = ctrl && wdata[0];
    full     = (fifoCount == CW'(FIFO_DEPTH));
    push_ok  = push_req && !full;
    avail    = !flush && (fifoCount != '0);
    pop      = avail && ((state == IDLE) || ((state == HOLD) && (cnt == HOLD_LAST)));
  end

  // Queue storage: bit 8 is RS (1 = pixel data, 0 = command).
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {bus.commAddr == ADDR_W'(2), wdata[7:0]};
  end

  // Queue pointers, occupancy and sticky overflow (set wins over clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifoCount <= '0;
      ovfErr    <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(push_ok);
      rd_ptr    <= flush ? wr_ptr : rd_ptr + PW'(pop);
      fifoCount <= (flush ? '0 : fifoCount) + CW'(push_ok) - CW'(pop);
      if (push_req && full) ovfErr <= 1'b1;
      else if (clr)         ovfErr <= 1'b0;
    end
  end

  // Write-cycle FSM with registered LCD strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lcdCs    <= 1'b1;
      lcdWr    <= 1'b1;
      lcdRs    <= 1'b1;
      dispData <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pop) begin
            state    <= SETUP;
            lcdCs    <= 1'b0;
            lcdRs    <= mem[rd_ptr][8];
            dispData <= mem[rd_ptr][7:0];
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= STROBE;
            lcdWr <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STROBE: begin
          if (cnt == WR_LAST) begin
            state <= HOLD;
            lcdWr <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (pop) begin
              state    <= SETUP;
              lcdRs    <= mem[rd_ptr][8];
              dispData <= mem[rd_ptr][7:0];
            end else begin
              state    <= IDLE;
              lcdCs    <= 1'b1;
              lcdRs    <= 1'b1;
              dispData <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level reference model.
module tb_lcd_write_sequencer;

  localparam int S     = 1;
  localparam int W     = 2;
  localparam int H     = 1;
  localparam int T     = S + W + H;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] dispData;
  logic       lcdRs, lcdWr, lcdRd, lcdCs, busy, ovfErr;
  logic [2:0] fifoCount;

  int checks   = 0;
  int failures = 0;

  lcd_write_sequencer_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  lcd_write_sequencer #(
    .DATA_W(8), .ADDR_W(3), .FIFO_DEPTH(DEPTH),
    .SETUP_CYC(S), .WR_LOW_CYC(W), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dispData(dispData), .lcdRs(lcdRs), .lcdWr(lcdWr), .lcdRd(lcdRd),
    .lcdCs(lcdCs), .busy(busy), .fifoCount(fifoCount), .ovfErr(ovfErr)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending writes and one in-flight write whose
  // age t (cycles since it was popped) determines the LCD pin levels.
  logic [8:0] q[$];
  bit         active;
  int         t;
  logic [8:0] cur;
  bit         ovf;

  task automatic model_reset();
    q.delete();
    active = 0;
    t      = 0;
    cur    = '0;
    ovf    = 0;
  endtask

  task automatic model_edge(input bit we, input logic [2:0] a, input logic [7:0] d);
    bit ctrl, push, full;
    ctrl = we && (a == 3'd1);
    push = we && (a == 3'd2 || a == 3'd3);
    full = (q.size() == DEPTH);
    if (ctrl && d[1]) q.delete();
    if (active) begin
      t++;
      if (t == T) active = 0;
    end
    if (!active && q.size() > 0) begin
      cur    = q.pop_front();
      active = 1;
      t      = 0;
    end
    if (push && !full) q.push_back({a == 3'd2, d});
    if (push && full) ovf = 1;
    else if (ctrl && d[0]) ovf = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit exp_wr;
    exp_wr = !(active && t >= S && t < S + W);
    chk("lcdCs",     lcdCs,     active ? 0 : 1);
    chk("lcdWr",     lcdWr,     exp_wr);
    chk("lcdRs",     lcdRs,     active ? cur[8] : 1);
    chk("dispData",  dispData,  active ? cur[7:0] : 0);
    chk("lcdRd",     lcdRd,     1);
    chk("busy",      busy,      (active || q.size() > 0) ? 1 : 0);
    chk("fifoCount", fifoCount, q.size());
    chk("ovfErr",    ovfErr,    ovf);
  endtask

  // One clock: present inputs, let the edge happen, update model, compare.
  task automatic step(input bit we, input logic [2:0] a, input logic [7:0] d);
    bus.wrEn     = we;
    bus.commAddr = a;
    bus.commData = d;
    @(posedge clk);
    model_edge(we, a, d);
    #1;
    check_model();
    bus.wrEn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 8'h00);
  endtask

  initial begin
    int   fall_cyc[$];
    logic [7:0] fall_dat[$];
    logic prev_wr;
    int   falls;
    logic [7:0] bdat;

    bus.wrEn = 1'b0; bus.commAddr = '0; bus.commData = '0;
    model_reset();

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", lcdCs, 1);   chk("rst_wr", lcdWr, 1);
    chk("rst_rs", lcdRs, 1);   chk("rst_rd", lcdRd, 1);
    chk("rst_data", dispData, 0); chk("rst_busy", busy, 0);
    chk("rst_count", fifoCount, 0); chk("rst_ovf", ovfErr, 0);
    @(negedge clk) rst = 1'b1;

    // Single command 0x2C: CS/data at N+1, WR low N+2..N+3, CS high at N+5.
    step(1, 3'd3, 8'h2C);
    step(0, 3'd0, 8'h00);
    chk("cmd_cs", lcdCs, 0); chk("cmd_rs", lcdRs, 0);
    chk("cmd_data", dispData, 8'h2C); chk("cmd_wr_setup", lcdWr, 1);
    step(0, 3'd0, 8'h00); chk("cmd_wr_low1", lcdWr, 0);
    step(0, 3'd0, 8'h00); chk("cmd_wr_low2", lcdWr, 0);
    step(0, 3'd0, 8'h00); chk("cmd_wr_hold", lcdWr, 1); chk("cmd_cs_hold", lcdCs, 0);
    step(0, 3'd0, 8'h00); chk("cmd_cs_end", lcdCs, 1); chk("cmd_busy_end", busy, 0);

    // Burst of four pixel writes: pulses 4 cycles apart, in order.
    prev_wr = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        bdat = 8'h11 * (i + 1);
        step(1, 3'd2, bdat);
      end else begin
        step(0, 3'd0, 8'h00);
      end
      if (prev_wr && !lcdWr) begin
        fall_cyc.push_back(i);
        fall_dat.push_back(dispData);
        chk("burst_rs", lcdRs, 1);
      end
      if (fall_cyc.size() > 0 && fall_cyc.size() < 4) chk("burst_cs_low", lcdCs, 0);
      prev_wr = lcdWr;
    end
    chk("burst_pulses", fall_cyc.size(), 4);
    for (int i = 0; i < fall_cyc.size() && i < 4; i++) begin
      bdat = 8'h11 * (i + 1);
      chk("burst_data", fall_dat[i], bdat);
      if (i > 0) chk("burst_spacing", fall_cyc[i] - fall_cyc[i-1], T);
    end

    // Overflow: six back-to-back writes, sixth rejected, then clear.
    for (int i = 0; i < 6; i++) step(1, 3'd2, 8'hA0 + 8'(i));
    chk("ovf_set", ovfErr, 1);
    chk("ovf_count", fifoCount, 3);
    step(1, 3'd1, 8'h01);
    chk("ovf_clear", ovfErr, 0);
    idle(20);

    // Flush during the first STROBE: in-flight write finishes, rest dropped.
    step(1, 3'd2, 8'h51); step(1, 3'd2, 8'h52); step(1, 3'd2, 8'h53);
    chk("flush_pre_strobe", lcdWr, 0);
    step(1, 3'd1, 8'h02);
    chk("flush_count", fifoCount, 0);
    chk("flush_inflight_data", dispData, 8'h51);
    falls = 0; prev_wr = lcdWr;
    for (int i = 0; i < 10; i++) begin
      step(0, 3'd0, 8'h00);
      if (prev_wr && !lcdWr) falls++;
      prev_wr = lcdWr;
    end
    chk("flush_no_pulses", falls, 0);
    chk("flush_busy", busy, 0);

    // Ignored address leaves everything alone.
    step(1, 3'd5, 8'hA5);
    chk("ign_count", fifoCount, 0); chk("ign_cs", lcdCs, 1);
    chk("ign_data", dispData, 0);   chk("ign_busy", busy, 0);

    // Asynchronous reset in the middle of a WR-low phase with a queued entry.
    step(1, 3'd2, 8'h77); step(1, 3'd3, 8'h78); step(0, 3'd0, 8'h00);
    chk("mid_wr_low", lcdWr, 0);
    rst = 1'b0;
    #1;
    chk("arst_wr", lcdWr, 1); chk("arst_cs", lcdCs, 1);
    chk("arst_count", fifoCount, 0); chk("arst_busy", busy, 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      step(1, ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd3, 8'($urandom));
      else if (r < 48) step(1, 3'd1, 8'($urandom_range(0, 3)));
      else if (r < 53) step(1, 3'(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(4, 7)), 8'($urandom));
      else             step(0, 3'd0, 8'($urandom));
    end
    idle(30);
    chk("final_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
